// File: rtl/prog_loader.sv
// Streams words into a DEPTH-entry memory (write mode) or checks memory contents
// against the stream (verify mode), tracking a running checksum and first mismatch.
module prog_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] checksum
);

  // state | meaning
  // IDLE  | waiting for load_start
  // WRITE | one word per cycle written at the current address
  // VRD   | read address presented, waiting for the stream word
  // VCMP  | memory data returned, compared with the held stream word
  typedef enum logic [1:0] {IDLE, WRITE, VRD, VCMP} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cmp_addr;
  logic [ADDR_WIDTH:0]   remain;
  logic [DATA_WIDTH-1:0] held_word;
  logic                  accept, len_ok, last, mismatch;

  always_comb begin
    len_ok    = (load_len != '0) && (load_len <= DEPTH);
    last      = (remain == LEN_ONE);
    mismatch  = (mem_rdata != held_word);
    busy      = (state != IDLE);
    in_ready  = !reset && ((state == WRITE) || (state == VRD));
    accept    = in_valid && in_ready;
    mem_we    = !reset && (state == WRITE) && in_valid;
    mem_wdata = (!reset && (state == WRITE)) ? in_data : '0;
    mem_addr  = '0;
    if (!reset) begin
      case (state)
        WRITE, VRD: mem_addr = cur_addr;
        VCMP:       mem_addr = cmp_addr;
        default:    mem_addr = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load_start && len_ok) state_nxt = mode ? VRD : WRITE;
      WRITE: if (abort || (accept && last)) state_nxt = IDLE;
      VRD:   if (abort) state_nxt = IDLE;
             else if (accept) state_nxt = VCMP;
      VCMP:  if (abort || last) state_nxt = IDLE;
             else state_nxt = VRD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cmp_addr  <= '0;
      remain    <= '0;
      held_word <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
      checksum  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (load_start) begin
          done  <= 1'b1;
          error <= 1'b1;
          if (len_ok) begin
            cur_addr <= load_base;
            remain   <= load_len;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
            checksum <= '0;
          end
        end
      end else begin
        if (accept) begin
          checksum <= checksum + in_data;
          cur_addr <= cur_addr + 1'b1;
        end
        if ((state == VRD) && accept) begin
          held_word <= in_data;
          cmp_addr  <= cur_addr;
        end
        // The last word counts only when the session is not being aborted
        if (!abort && (((state == WRITE) && accept) || (state == VCMP))) begin
          remain <= remain - 1'b1;
          if (last) done <= 1'b1;
        end
        if ((state == VCMP) && !abort && mismatch && !error) begin
          error    <= 1'b1;
          err_addr <= cmp_addr;
        end
        if (abort) begin
          error <= 1'b1;
          done  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes go into a scoreboard
// queue, a monitor pops them as mem_we pulses; session status checked directly.
module tb_prog_loader;

  logic       clock = 1'b0;
  logic       reset, load_start, mode, abort, in_valid;
  logic [4:0] load_base;
  logic [5:0] load_len;
  logic [7:0] in_data, mem_rdata, mem_wdata, checksum;
  logic       in_ready, mem_we, busy, done, error;
  logic [4:0] mem_addr, err_addr;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  mem [0:31];

  prog_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .mode(mode),
    .load_base(load_base), .load_len(load_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error),
    .err_addr(err_addr), .checksum(checksum)
  );

  always #5 clock = ~clock;

  // synchronous memory: read data valid the cycle after the address
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // write monitor
  always @(negedge clock) begin
    if (mem_we) begin
      logic [12:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                   mem_addr, mem_wdata, e[12:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic m, input logic [4:0] base, input logic [5:0] len);
    load_start = 1'b1; mode = m; load_base = base; load_len = len;
    tick();
    load_start = 1'b0;
  endtask

  // drive one word once in_ready is up; leaves in_valid high for back-to-back use
  task automatic send(input logic [7:0] d, input logic [4:0] addr, input bit wr);
    int n = 0;
    while (!in_ready && n < 20) begin
      in_valid = 1'b0;
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    if (wr) exp_q.push_back({addr, d});
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("busy_timeout", 1, 0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic [4:0] ea, input logic [7:0] cs);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, d);
    check({tag, "_error"}, error, e);
    check({tag, "_err_addr"}, err_addr, ea);
    check({tag, "_checksum"}, checksum, cs);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check_status(tag, 0, 0, 5'h00, 8'h00);
  endtask

  logic [7:0] s21 [32] = '{8'hFE,8'h00,8'h00,8'hBA,8'h20,8'h00,8'hBB,8'h20,
                           8'hEA,8'h00,8'hDC,8'hBA,8'hDC,8'hBC,8'h20,8'h00,
                           8'h9B,8'h20,8'hF4,8'h00,8'h9B,8'h20,8'h00,8'h00,
                           8'hE0,8'h00,8'h00,8'hFF,8'hAA,8'h00,8'hE3,8'h00};
  logic [7:0] s22 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] sbad [4] = '{8'h11, 8'h22, 8'h30, 8'h40};

  initial begin
    reset = 1'b1; load_start = 1'b0; mode = 1'b0; load_base = '0; load_len = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_zero("reset");

    // 32-word back-to-back write from base 0
    start(1'b0, 5'h00, 6'd32);
    check("write_busy", busy, 1);
    check("write_in_ready", in_ready, 1);
    for (int i = 0; i < 32; i++) send(s21[i], 5'(i), 1'b1);
    wait_idle();
    check_status("write32", 1, 0, 5'h00, 8'hC1);

    // verify with word 5 altered to 0x01
    start(1'b1, 5'h00, 6'd32);
    check("verify_busy", busy, 1);
    for (int i = 0; i < 32; i++) send((i == 5) ? 8'h01 : s21[i], 5'(i), 1'b0);
    wait_idle();
    check_status("verify32", 1, 1, 5'h05, 8'hC2);

    // wrapping write with an idle cycle between words
    start(1'b0, 5'h1E, 6'd4);
    for (int i = 0; i < 4; i++) begin
      send(s22[i], 5'(5'h1E + 5'(i)), 1'b1);
      in_valid = 1'b0;
      tick();
    end
    wait_idle();
    check_status("wrap_write", 1, 0, 5'h00, 8'hAA);

    // two mismatches: only the first is reported
    start(1'b1, 5'h1E, 6'd4);
    for (int i = 0; i < 4; i++) send(sbad[i], 5'h00, 1'b0);
    wait_idle();
    check_status("verify_two_bad", 1, 1, 5'h00, 8'hA3);

    start(1'b1, 5'h1E, 6'd4);
    for (int i = 0; i < 4; i++) send(s22[i], 5'h00, 1'b0);
    wait_idle();
    check_status("verify_clean", 1, 0, 5'h00, 8'hAA);

    // abort while idle is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_status("idle_abort", 1, 0, 5'h00, 8'hAA);

    // illegal lengths do not start a session
    start(1'b0, 5'h00, 6'd0);
    check("len0_busy", busy, 0);
    check("len0_error", error, 1);
    check("len0_done", done, 1);
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    start(1'b0, 5'h00, 6'd33);
    check("len33_busy", busy, 0);
    check("len33_error", error, 1);
    check("len33_done", done, 1);
    in_valid = 1'b1;
    tick();
    check("len33_busy_later", busy, 0);
    in_valid = 1'b0;

    // abort coincident with the third word: that word still lands
    start(1'b0, 5'h04, 6'd8);
    send(8'h01, 5'h04, 1'b1);
    send(8'h02, 5'h05, 1'b1);
    abort = 1'b1;
    send(8'h03, 5'h06, 1'b1);
    abort = 1'b0;
    in_data = 8'hFF;
    tick();
    tick();
    in_valid = 1'b0;
    check_status("abort", 0, 1, 5'h00, 8'h06);

    // reset in the middle of a session
    start(1'b0, 5'h08, 6'd8);
    send(8'h10, 5'h08, 1'b1);
    send(8'h20, 5'h09, 1'b1);
    send(8'h30, 5'h0A, 1'b1);
    check("pre_reset_checksum", checksum, 8'h60);
    reset = 1'b1;
    in_data = 8'h55;
    tick();
    reset = 1'b0;
    tick();
    check_zero("mid_reset");
    in_valid = 1'b0;

    repeat (3) tick();
    check("final_pending_writes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the instruction/data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the memory address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have ports, clock and reset first:
 clock  in  1  single clock; all state updates on rising edge
 reset  in  1  synchronous, active-high reset
 load_start  in  1  one-cycle request to start a session, sampled in IDLE only
 mode  in  1  0 = write, 1 = verify; sampled with load_start
 load_base  in  ADDR_WIDTH  first address; sampled with load_start
 load_len  in  ADDR_WIDTH+1  word count, legal 1..DEPTH; sampled with load_start
 abort  in  1  terminate the active session
 in_valid  in  1  stream word valid
 in_data  in  DATA_WIDTH  stream word
 in_ready  out  1  loader accepts in_data this cycle
 mem_we  out  1  memory write strobe
 mem_addr  out  ADDR_WIDTH  memory address
 mem_wdata  out  DATA_WIDTH  memory write data
 mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr
 busy  out  1  session active; CPU held off while high
 done  out  1  session completed, held until next accepted load_start
 error  out  1  session failed, held until next accepted load_start
 err_addr  out  ADDR_WIDTH  address of first verify mismatch
 checksum  out  DATA_WIDTH  sum mod 2**DATA_WIDTH of accepted words

Function
REQ-004 SHALL implement states IDLE, WRITE, VRD, VCMP.
REQ-005 In IDLE, load_start=1 SHALL latch mode/base/len, clear done, error, err_addr and checksum, and enter WRITE (mode 0) or VRD (mode 1) next cycle.
REQ-006 load_start with load_len=0 or >DEPTH SHALL NOT start a session; next cycle error=1, done=1, state stays IDLE, no mem_we.
REQ-007 load_start outside IDLE SHALL be ignored.
REQ-008 busy SHALL be 1 exactly when state is not IDLE.
REQ-009 in_ready SHALL be 1 in WRITE and VRD, 0 in IDLE and VCMP.
REQ-010 A word is accepted when in_valid and in_ready are both 1; no word is accepted otherwise, in_valid gaps of any length allowed.
REQ-011 In WRITE, mem_we SHALL equal in_valid, with mem_addr = current address and mem_wdata = in_data combinationally, same cycle.
REQ-012 Current address SHALL start at load_base and increment by 1 per accepted word, wrapping DEPTH-1 -> 0.
REQ-013 checksum SHALL add each accepted word mod 2**DATA_WIDTH, updating the cycle after acceptance.
REQ-014 In VRD, mem_addr SHALL be the current address, mem_we 0; an accepted word is stored and state goes to VCMP.
REQ-015 In VCMP, mem_rdata SHALL be compared with the stored word; on first mismatch error=1 and err_addr=that address; later mismatches do not change err_addr; state returns to VRD or finishes.
REQ-016 Write throughput SHALL be 1 word/cycle; verify 1 word per 2 cycles.
REQ-017 After the load_len-th word (WRITE) or comparison (VCMP), state SHALL return to IDLE next cycle with done=1, busy=0.
REQ-018 abort=1 while busy SHALL return to IDLE next cycle, error=1, done=0; a word handshaken in the abort cycle is still written/counted; abort in IDLE ignored.
REQ-019 mem_we SHALL never be 1 outside WRITE.

Reset
REQ-020 reset=1 SHALL force state IDLE; in_ready, mem_we, busy, done, error = 0; mem_addr, mem_wdata, err_addr, checksum = 0; overrides all other inputs including mid-session, abandoning remaining words.

Verification
REQ-021 Write base 0x00, len 32, stream FE,00,00,BA,20,00,BB,20,EA,00,DC,BA,DC,BC,20,00,9B,20,F4,00,9B,20,00,00,E0,00,00,FF,AA,00,E3,00 back-to-back -> 32 mem_we pulses at addresses 0x00..0x1F, done=1, error=0, checksum=0xC1.
REQ-022 Write base 0x1E, len 4, data 11,22,33,44 with one idle in_valid cycle between each -> writes at 1E,1F,00,01 only on valid cycles, checksum=0xAA, done=1.
REQ-023 Verify after REQ-021 load with same stream except word 0x05 = 0x01 -> no mem_we, error=1, err_addr=0x05, done=1, checksum=0xC2.
REQ-024 load_start with load_len=0, then with load_len=33 -> error=1, done=1, busy stays 0, no mem_we.
REQ-025 Write len 8, abort after 3 words; separately reset after 3 words -> abort: error=1, done=0, busy=0, exactly 3 writes; reset: all outputs 0, no further mem_we.
